// File: rtl/eth_pkg.sv
`default_nettype none
// eth_pkg -- shared state encoding, GMII framing constants and wire-byte helpers. Rev 1.0
package eth_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_PRE  = 3'd1;
   localparam state_t ST_SFD  = 3'd2;
   localparam state_t ST_DATA = 3'd3;
   localparam state_t ST_IPG  = 3'd4;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam int         PREAMBLE_LEN  = 7;

   function automatic logic tx_active(state_t st);
      return (st == ST_PRE) || (st == ST_SFD) || (st == ST_DATA);
   endfunction

   function automatic logic [7:0] tx_byte(state_t st, logic [7:0] payload);
      case (st)
         ST_PRE:  return PREAMBLE_BYTE;
         ST_SFD:  return SFD_BYTE;
         ST_DATA: return payload;
         default: return 8'h00;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rr_arb2.sv
`default_nettype none
// eth_rr_arb2 -- two-way round-robin arbiter; pointer moves on the frame-end strobe. Rev 1.0
module eth_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       served_i,
   output logic [1:0] gnt_o
);

   logic last_q, last_d;

   // On a tie the source that was not served last wins.
   always_comb begin
      gnt_o = 2'b00;
      if (req_i[0] && (!req_i[1] || last_q)) begin
         gnt_o = 2'b01;
      end else if (req_i[1]) begin
         gnt_o = 2'b10;
      end
   end

   always_comb begin
      last_d = last_q;
      if (upd_i) begin
         last_d = served_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// eth_tx_arb -- two-source round-robin GMII transmitter: preamble, SFD, payload, IPG. Rev 1.0
module eth_tx_arb
   import eth_pkg::*;
#(
   parameter int IPG_BYTES = 12,
   parameter int MAX_FRAME = 1518
) (
   input  logic        i_tx_clk,
   input  logic        rst_n,
   input  logic        i_en,
   input  logic [1:0]  i_req,
   input  logic [7:0]  i_data0,
   input  logic [7:0]  i_data1,
   input  logic        i_last0,
   input  logic        i_last1,
   output logic [1:0]  o_gnt,
   output logic [1:0]  o_rd,
   output logic [1:0]  o_done,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_en,
   output logic        o_trunc,
   output logic [15:0] o_frame_cnt
);

   localparam int CNT_SPAN = (MAX_FRAME > IPG_BYTES) ? MAX_FRAME : IPG_BYTES;
   localparam int CW       = $clog2(CNT_SPAN + PREAMBLE_LEN);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    done_q, done_d;
   logic          trunc_q, trunc_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          tx_en_q;
   logic [7:0]    tx_data_q;
   logic [1:0]    arb_gnt;
   logic          arb_upd;
   logic          sel_last;
   logic [7:0]    sel_data;

   eth_rr_arb2 u_arb (
      .clk_i    (i_tx_clk),
      .rst_n    (rst_n),
      .req_i    (i_req),
      .upd_i    (arb_upd),
      .served_i (gnt_q[1]),
      .gnt_o    (arb_gnt)
   );

   assign sel_last = gnt_q[1] ? i_last1 : i_last0;
   assign sel_data = gnt_q[1] ? i_data1 : i_data0;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      done_d      = 2'b00;
      trunc_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;
      arb_upd     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_en && (|i_req)) begin
               state_d = ST_PRE;
               gnt_d   = arb_gnt;
               cnt_d   = '0;
            end
         end
         ST_PRE: begin
            if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
               state_d = ST_SFD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SFD: begin
            state_d = ST_DATA;
            cnt_d   = '0;
         end
         ST_DATA: begin
            if (sel_last || (cnt_q == CW'(MAX_FRAME - 1))) begin
               state_d     = ST_IPG;
               cnt_d       = '0;
               gnt_d       = 2'b00;
               done_d      = gnt_q;
               trunc_d     = !sel_last;
               frame_cnt_d = frame_cnt_q + 16'd1;
               arb_upd     = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_IPG: begin
            // The IDLE arbitration cycle supplies the last idle byte of the gap.
            if (cnt_q == CW'(IPG_BYTES - 2)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge i_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         gnt_q       <= 2'b00;
         done_q      <= 2'b00;
         trunc_q     <= 1'b0;
         frame_cnt_q <= 16'd0;
         tx_en_q     <= 1'b0;
         tx_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         trunc_q     <= trunc_d;
         frame_cnt_q <= frame_cnt_d;
         tx_en_q     <= tx_active(state_q);
         tx_data_q   <= tx_byte(state_q, sel_data);
      end
   end

   assign o_gnt       = gnt_q;
   assign o_rd        = (state_q == ST_DATA) ? gnt_q : 2'b00;
   assign o_done      = done_q;
   assign o_trunc     = trunc_q;
   assign o_frame_cnt = frame_cnt_q;
   assign o_tx_en     = tx_en_q;
   assign o_tx_data   = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// tb_eth_tx_arb -- frame-level reference model of the two-source GMII arbiter. Rev 1.0
module tb_eth_tx_arb;

   localparam int IPG   = 12;
   localparam int MAXF  = 1518;
   localparam int LIMIT = 4000;

   typedef struct {
      int         len;
      logic [7:0] seed;
      bit         inf;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_en = 1'b0;
   logic [1:0]  i_req = 2'b00;
   logic [7:0]  i_data0 = 8'h00;
   logic [7:0]  i_data1 = 8'h00;
   logic        i_last0 = 1'b0;
   logic        i_last1 = 1'b0;
   logic [1:0]  o_gnt;
   logic [1:0]  o_rd;
   logic [1:0]  o_done;
   logic [7:0]  o_tx_data;
   logic        o_tx_en;
   logic        o_trunc;
   logic [15:0] o_frame_cnt;

   eth_tx_arb #(.IPG_BYTES(IPG), .MAX_FRAME(MAXF)) dut (
      .i_tx_clk    (clk),
      .rst_n       (rst_n),
      .i_en        (i_en),
      .i_req       (i_req),
      .i_data0     (i_data0),
      .i_data1     (i_data1),
      .i_last0     (i_last0),
      .i_last1     (i_last1),
      .o_gnt       (o_gnt),
      .o_rd        (o_rd),
      .o_done      (o_done),
      .o_tx_data   (o_tx_data),
      .o_tx_en     (o_tx_en),
      .o_trunc     (o_trunc),
      .o_frame_cnt (o_frame_cnt)
   );

   initial forever #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   frame_t      cur [2];
   int          idx [2];
   frame_t      pend0 [$];
   frame_t      pend1 [$];
   int          zero_run = 0;
   int          last_gap = 0;
   logic        prev_en = 1'b0;
   int          done_cnt [2];
   int          trunc_cnt = 0;
   int          cnt_at_done = -1;
   int          trunc_at_done = -1;
   bit          drop_en_in_data = 1'b0;
   int          last_srv = 1;
   logic [15:0] exp_cnt = 16'd0;

   task automatic check(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic frame_t rnd_frame();
      frame_t f;
      f.len  = int'($urandom_range(1, 40));
      f.seed = 8'($urandom);
      f.inf  = 1'b0;
      return f;
   endfunction

   function automatic void load(int k);
      if (k == 0) begin
         if (pend0.size() > 0) begin
            cur[0] = pend0.pop_front(); idx[0] = 0; i_req[0] = 1'b1;
         end else i_req[0] = 1'b0;
      end else begin
         if (pend1.size() > 0) begin
            cur[1] = pend1.pop_front(); idx[1] = 0; i_req[1] = 1'b1;
         end else i_req[1] = 1'b0;
      end
   endfunction

   // Each source presents byte seed+k; last flag on byte len-1 unless endless.
   function automatic void drive();
      i_data0 = cur[0].seed + 8'(idx[0]);
      i_data1 = cur[1].seed + 8'(idx[1]);
      i_last0 = !cur[0].inf && (idx[0] == cur[0].len - 1);
      i_last1 = !cur[1].inf && (idx[1] == cur[1].len - 1);
   endfunction

   task automatic step();
      logic [1:0] rd_pre;
      rd_pre = o_rd;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (rd_pre[k]) idx[k]++;
      if (o_tx_en && !prev_en) last_gap = zero_run;
      zero_run = o_tx_en ? 0 : zero_run + 1;
      prev_en  = o_tx_en;
      if (o_trunc) trunc_cnt++;
      for (int k = 0; k < 2; k++) begin
         if (o_done[k]) begin
            done_cnt[k]++;
            cnt_at_done   = int'(o_frame_cnt);
            trunc_at_done = int'(o_trunc);
            load(k);
         end
      end
      if (drop_en_in_data && (|o_rd)) begin
         i_en = 1'b0;
         drop_en_in_data = 1'b0;
      end
      drive();
   endtask

   task automatic expect_frame(string tag, int src, bit chk_gap);
      frame_t     f;
      logic [7:0] got [$];
      logic [7:0] e;
      logic [1:0] g;
      int         n, gap, d0, d1, t0, len;
      bit         ok;
      f  = cur[src];
      d0 = done_cnt[0];
      d1 = done_cnt[1];
      t0 = trunc_cnt;
      n  = 0;
      while (!o_tx_en && n < LIMIT) begin step(); n++; end
      g   = o_gnt;
      gap = last_gap;
      while (o_tx_en && n < LIMIT) begin got.push_back(o_tx_data); step(); n++; end
      check({tag, "_timeout"}, int'(n < LIMIT), 1);
      len = f.inf ? MAXF : f.len;
      exp_cnt++;
      last_srv = src;
      check({tag, "_gnt"}, int'(g), 1 << src);
      if (chk_gap) check({tag, "_gap"}, gap, IPG);
      check({tag, "_len"}, got.size(), len + 8);
      ok = 1'b1;
      for (int i = 0; i < got.size(); i++) begin
         e = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : f.seed + 8'(i - 8);
         if (got[i] !== e) ok = 1'b0;
      end
      check({tag, "_bytes"}, int'(ok), 1);
      check({tag, "_done_src"}, (src == 0) ? done_cnt[0] - d0 : done_cnt[1] - d1, 1);
      check({tag, "_done_oth"}, (src == 0) ? done_cnt[1] - d1 : done_cnt[0] - d0, 0);
      check({tag, "_trunc"}, trunc_cnt - t0, int'(f.inf));
      if (f.inf) check({tag, "_trunc_with_done"}, trunc_at_done, 1);
      check({tag, "_frame_cnt"}, cnt_at_done, int'(exp_cnt));
   endtask

   // Round-robin order from the pending work of each source.
   task automatic run_plan(string tag);
      int n0;
      int n1;
      int total;
      int pick;
      n0    = pend0.size() + int'(i_req[0]);
      n1    = pend1.size() + int'(i_req[1]);
      total = n0 + n1;
      for (int i = 0; i < total; i++) begin
         if (n0 > 0 && n1 > 0) pick = (last_srv == 0) ? 1 : 0;
         else pick = (n0 > 0) ? 0 : 1;
         expect_frame($sformatf("%s%0d", tag, i), pick, i > 0);
         if (pick == 0) n0--; else n1--;
      end
   endtask

   initial begin
      int hi;
      int n;
      int dsum;
      frame_t f;
      for (int k = 0; k < 2; k++) begin
         cur[k] = '{1, 8'h00, 1'b0};
         idx[k] = 0;
         done_cnt[k] = 0;
      end
      drive();
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_en", int'(o_tx_en), 0);
      check("rst_tx_data", int'(o_tx_data), 0);
      check("rst_gnt", int'(o_gnt), 0);
      check("rst_rd", int'(o_rd), 0);
      check("rst_done", int'(o_done), 0);
      check("rst_trunc", int'(o_trunc), 0);
      check("rst_frame_cnt", int'(o_frame_cnt), 0);
      rst_n = 1'b1;

      i_en = 1'b1;
      pend0.push_back('{4, 8'h01, 1'b0});
      load(0); drive();
      expect_frame("single", 0, 1'b0);

      i_en = 1'b0;
      pend0.push_back(rnd_frame());
      load(0); drive();
      hi = 0;
      repeat (50) begin step(); if (o_tx_en) hi++; end
      check("en_low_quiet", hi, 0);
      i_en = 1'b1;
      step();
      check("en_rise_c1", int'(o_tx_en), 0);
      step();
      check("en_rise_c2_en", int'(o_tx_en), 1);
      check("en_rise_c2_data", int'(o_tx_data), 8'h55);
      drop_en_in_data = 1'b1;
      expect_frame("en_drop", 0, 1'b0);
      i_en = 1'b1;

      for (int i = 0; i < 3; i++) begin
         pend0.push_back(rnd_frame());
         pend1.push_back(rnd_frame());
      end
      load(0); load(1); drive();
      run_plan("rr");

      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) pend0.push_back(rnd_frame());
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) pend1.push_back(rnd_frame());
      load(0); load(1); drive();
      run_plan("mix");

      f = rnd_frame();
      f.inf = 1'b1;
      pend1.push_back(f);
      pend0.push_back(rnd_frame());
      load(0); load(1); drive();
      run_plan("trunc");

      pend0.push_back('{30, 8'($urandom), 1'b0});
      load(0); drive();
      n = 0;
      while (!(o_rd[0] && idx[0] == 9) && n < LIMIT) begin step(); n++; end
      check("rst_reach_byte10", int'(n < LIMIT), 1);
      dsum = done_cnt[0] + done_cnt[1];
      rst_n = 1'b0;
      #1;
      check("midrst_tx_en", int'(o_tx_en), 0);
      check("midrst_gnt", int'(o_gnt), 0);
      check("midrst_rd", int'(o_rd), 0);
      check("midrst_frame_cnt", int'(o_frame_cnt), 0);
      step(); step();
      rst_n = 1'b1;
      last_srv = 1;
      exp_cnt  = 16'd0;
      pend0.push_back(rnd_frame());
      load(0); drive();
      step();
      check("midrst_no_done", done_cnt[0] + done_cnt[1], dsum);
      expect_frame("after_rst", 0, 1'b0);

      force dut.frame_cnt_q = 16'hFFFF;
      step();
      release dut.frame_cnt_q;
      step();
      check("preload", int'(o_frame_cnt), 16'hFFFF);
      exp_cnt = 16'hFFFF;
      pend1.push_back(rnd_frame());
      load(1); drive();
      run_plan("wrap");

      repeat (20) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 SHALL have parameter IPG_BYTES, default 12, number of idle tx_en=0 cycles between frames.
REQ-002 SHALL have parameter MAX_FRAME, default 1518, maximum payload bytes per frame before forced truncation.
REQ-003 SHALL have port i_tx_clk  input  1  single clock, GMII byte clock (PLL TX clock); all logic in this domain.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port i_en  input  1  when low, no new grant is issued; a frame in progress completes.
REQ-006 SHALL have port i_req  input  2  per-source frame request, level, held until o_done for that source.
REQ-007 SHALL have port i_data0 / i_data1  input  8 each  current payload byte of source 0 / 1.
REQ-008 SHALL have port i_last0 / i_last1  input  1 each  current byte is the final payload byte.
REQ-009 SHALL have port o_gnt  output  2  one-hot grant, held from grant until frame end.
REQ-010 SHALL have port o_rd  output  2  byte-consume strobe to the granted source; source presents next byte the following cycle.
REQ-011 SHALL have port o_done  output  2  one-cycle pulse, frame of that source finished.
REQ-012 SHALL have port o_tx_data  output  8  GMII byte to the DDR output stage.
REQ-013 SHALL have port o_tx_en  output  1  GMII transmit enable.
REQ-014 SHALL have port o_trunc  output  1  one-cycle pulse on MAX_FRAME truncation.
REQ-015 SHALL have port o_frame_cnt  output  16  count of frames completed, all sources.

Function
REQ-016 SHALL implement states IDLE, PRE, SFD, DATA, IPG.
REQ-017 IDLE: if i_en=1 and any i_req bit set, SHALL latch grant and enter PRE next cycle; o_gnt valid from the first PRE cycle.
REQ-018 Arbitration SHALL be round-robin: on both requests, grant the source not served last; single request granted directly; pointer resets to "source 1 last served" (source 0 wins first tie).
REQ-019 PRE SHALL last 7 cycles, SFD 1 cycle; DATA SHALL run until the byte with i_lastN=1 is consumed.
REQ-020 o_rd[k] SHALL be combinational = (state==DATA) and o_gnt[k]; exactly one byte consumed per DATA cycle, no stalls.
REQ-021 o_tx_en/o_tx_data SHALL be registered: output at cycle t+1 reflects state at t; PRE emits 0x55, SFD 0xD5, DATA the consumed byte, other states tx_en=0, data=0x00.
REQ-022 End of frame: DATA -> IPG; o_done[k] pulses and o_frame_cnt increments in the first IPG cycle; o_gnt clears then.
REQ-023 IPG SHALL hold exactly IPG_BYTES cycles (tx_en=0 on wire), then IDLE; a new grant can be taken in IDLE the cycle after.
REQ-024 Byte counter SHALL count DATA cycles; if MAX_FRAME bytes consumed without i_last, SHALL end frame as in REQ-022 and pulse o_trunc in the same cycle as o_done.
REQ-025 o_frame_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-026 i_en deassertion or i_req withdrawal mid-frame SHALL not alter the frame in progress.
REQ-027 i_req of the non-granted source SHALL be ignored until IDLE.

Reset
REQ-028 On rst_n=0, asynchronously: state IDLE, o_tx_en=0, o_tx_data=0x00, o_gnt=0, o_rd=0, o_done=0, o_trunc=0, o_frame_cnt=0, byte/IPG counters 0, RR pointer per REQ-018.
REQ-029 Reset mid-frame SHALL drop o_tx_en immediately; no completion pulse or count is issued for the aborted frame.

Structure
REQ-030 State enum, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, PREAMBLE_LEN=7 SHALL live in shared package eth_pkg.
REQ-031 Round-robin two-way arbiter SHALL be sub-module eth_rr_arb2 (request in, one-hot grant out, pointer update on frame-end strobe).

Verification
REQ-032 Source 0 alone, 4-byte frame 0x01..0x04: wire shows 7x0x55, 0xD5, 01 02 03 04, tx_en high 12 cycles; o_done[0] once; o_frame_cnt=1.
REQ-033 Both request, 3 frames each back-to-back: grants alternate 0,1,0,1,0,1; every inter-frame gap exactly 12 tx_en=0 cycles.
REQ-034 Source 1 frame with i_last never asserted: exactly 1518 payload bytes sent, o_trunc and o_done[1] pulse together, next IPG intact.
REQ-035 i_en=0 with i_req=01: no tx_en for 50 cycles; i_en=1 -> first 0x55 two cycles later; i_en dropped mid-DATA: frame completes.
REQ-036 rst_n pulsed low in DATA byte 10: o_tx_en=0 same cycle, o_frame_cnt stays 0, next frame starts clean from PRE.
REQ-037 Preload 0xFFFF frames (via run or force): next completion gives o_frame_cnt=0x0000.
